multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control unit that sequences the shared multicycle RV32I-subset datapath: one memory port, one ALU, and IR/ALUOut/Data holding registers.
- Decodes the IR opcode and steps through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux/enable and stalls on a memory ready handshake.
- Also provides a retired-instruction counter and an illegal-opcode flag for the processor testbench.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0] of the current instruction
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current access this cycle
pc_write  output  1  PC enable, equal to pc_update OR (branch AND zero)
adr_src  output  1  0 = memory address from PC, 1 = address from ALUOut
mem_write  output  1  memory write strobe
ir_write  output  1  IR and oldPC load enable
reg_write  output  1  register file write enable
result_src  output  2  00 ALUOut, 01 Data, 10 ALU result
alu_src_a  output  2  00 PC, 01 oldPC, 10 regA, 11 constant zero
alu_src_b  output  2  00 regB, 01 immediate, 10 constant 4, 11 U-immediate
alu_op  output  2  00 add, 01 subtract (branch compare), 10 funct-decoded
illegal  output  1  unknown opcode detected in DECODE
state  output  4  current state encoding, for debug
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset: on `clk` edge with `reset`=1, state=FETCH (0) and retired=0; reset mid-instruction abandons it.
- All outputs are combinational from state, mem_ready and opcode. Every output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXER=6, ALUWB=7, EXEI=8, BEQ=9, JAL=10, LUI=11. Encodings 12-15 go to FETCH on the next edge.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, alu_op=00.
  - ir_write=1 and pc_update=1 only while mem_ready=1.
  - mem_ready=1 -> DECODE; otherwise hold in FETCH with ir_write and pc_write held at 0.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes the branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXER
  - 0010011 -> EXEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other opcode -> FETCH, with illegal=1 during that DECODE cycle
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMRD if opcode=0000011, else MEMWR.
- MEMRD: adr_src=1, result_src=00. Hold until mem_ready=1, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWR: adr_src=1, result_src=00, mem_write=1 held for the whole wait. Hold until mem_ready=1, then FETCH.
- EXER: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
- LUI: alu_src_a=11, alu_src_b=11, alu_op=00. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 (so pc_write=zero). Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next ALUWB, which writes PC+4 to rd.
- Retired counter:
  - Increments by 1 on each edge leaving MEMWB, ALUWB, BEQ, or MEMWR with mem_ready=1.
  - Does not increment on the illegal-opcode path or on a forced return from encodings 12-15.
  - Wraps modulo 2^CNT_W.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- Latencies with zero wait states:
  - BEQ: 3 cycles
  - R-type, I-type ALU, LUI, JAL, SW: 4 cycles
  - LW: 5 cycles
  - Each wait cycle adds 1.

Test Plan:
- Reset with mem_ready=1 and opcode=0110011 for 4 cycles -> state sequence 0,1,6,7,0. Outputs: ir_write=1 and pc_write=1 in cycle 1, reg_write=1 in cycle 4, retired=1.
- opcode=0000011 with mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD -> FETCH held 3 cycles with ir_write=0 until mem_ready. Then states 1,2; MEMRD 4 cycles with adr_src=1; then MEMWB with result_src=01 and reg_write=1. Total 10 cycles, retired +1.
- opcode=1100011: with zero=1 -> in BEQ pc_write=1, alu_op=01. With zero=0 -> pc_write=0. Both runs take 3 cycles and retired +1.
- opcode=0100011 with mem_ready=0 for 2 cycles in MEMWR -> mem_write=1 for 3 consecutive cycles, reg_write never asserted, then FETCH.
- opcode=0000000 -> illegal=1 for exactly the DECODE cycle, next state FETCH, retired unchanged.
- reset=1 asserted while in MEMRD -> next state 0, retired=0, all strobes 0 apart from the FETCH-state defaults.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the shared multicycle RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_ready, counts retired instructions.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instruction at PC, load IR/oldPC, PC <= PC+4
// DECODE | read registers, ALU computes branch target oldPC+imm
// MEMADR | ALU computes load/store address regA+imm
// MEMRD  | load access at ALUOut, waits for mem_ready
// MEMWB  | write loaded Data into rd
// MEMWR  | store access at ALUOut, strobe held until mem_ready
// EXER   | R-type ALU operation regA op regB
// ALUWB  | write ALUOut into rd
// EXEI   | I-type ALU operation regA op imm
// BEQ    | compare regA-regB, PC <= ALUOut (target) when zero
// JAL    | PC <= target, ALU computes oldPC+4 for the link
// LUI    | ALU computes 0 + U-immediate

module multicycle_control_fsm #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             adr_src,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXER   = 4'd6,
      S_ALUWB  = 4'd7,
      S_EXEI   = 4'd8,
      S_BEQ    = 4'd9,
      S_JAL    = 4'd10,
      S_LUI    = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_OLDPC = 2'b01;
   localparam logic [1:0] A_REGA  = 2'b10;
   localparam logic [1:0] A_ZERO  = 2'b11;

   localparam logic [1:0] B_REGB  = 2'b00;
   localparam logic [1:0] B_IMM   = 2'b01;
   localparam logic [1:0] B_FOUR  = 2'b10;
   localparam logic [1:0] B_UIMM  = 2'b11;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_FUNC = 2'b10;

   state_t state_q;
   state_t state_d;
   logic   pc_update;
   logic   branch;
   logic   retire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         retired <= '0;
      end else begin
         state_q <= state_d;
         if (retire) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d    = S_FETCH;
      pc_update  = 1'b0;
      branch     = 1'b0;
      retire     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = A_PC;
      alu_src_b  = B_REGB;
      alu_op     = OP_ADD;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            alu_src_b  = B_FOUR;
            result_src = RES_ALU;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_update = 1'b1;
               state_d   = S_DECODE;
            end else begin
               state_d   = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXER;
               OP_ITYPE:          state_d = S_EXEI;
               OP_BEQ:            state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               OP_LUI:            state_d = S_LUI;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = A_REGA;
            alu_src_b = B_IMM;
            state_d   = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adr_src = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            retire    = mem_ready;
            state_d   = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXER: begin
            alu_src_a = A_REGA;
            alu_src_b = B_REGB;
            alu_op    = OP_FUNC;
            state_d   = S_ALUWB;
         end
         S_EXEI: begin
            alu_src_a = A_REGA;
            alu_src_b = B_IMM;
            alu_op    = OP_FUNC;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a = A_ZERO;
            alu_src_b = B_UIMM;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a = A_REGA;
            alu_src_b = B_REGB;
            alu_op    = OP_SUB;
            branch    = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            // The link value oldPC+4 is formed here and written back in ALUWB.
            alu_src_a = A_OLDPC;
            alu_src_b = B_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign pc_write = pc_update | (branch & zero);
   assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction-level bench for multicycle_control_fsm.
// Expected state paths come from the opcode/latency table; outputs from a per-state table.

module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  opcode = 7'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
   logic [3:0]  state;
   logic [31:0] retired;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] model_ret = '0;
   int          exp_st[$];
   bit          exp_mr[$];

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] IT   = 7'b0010011;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JL   = 7'b1101111;
   localparam logic [6:0] LU   = 7'b0110111;

   multicycle_control_fsm #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .state(state),
      .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic bit is_legal(logic [6:0] op);
      return op inside {LW, SW, RT, IT, BR, JL, LU};
   endfunction

   // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, illegal}
   function automatic logic [13:0] ctrl_exp(int st, bit mr, bit z, bit ill);
      logic pcw, adr, mw, irw, rw, il;
      logic [1:0] rs, a, b, op;
      {pcw, adr, mw, irw, rw, il} = '0;
      {rs, a, b, op} = '0;
      case (st)
         0:  begin b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         1:  begin a = 2'b01; b = 2'b01; il = ill; end
         2:  begin a = 2'b10; b = 2'b01; end
         3:  begin adr = 1'b1; end
         4:  begin rs = 2'b01; rw = 1'b1; end
         5:  begin adr = 1'b1; mw = 1'b1; end
         6:  begin a = 2'b10; b = 2'b00; op = 2'b10; end
         7:  begin rw = 1'b1; end
         8:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
         9:  begin a = 2'b10; op = 2'b01; pcw = z; end
         10: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
         11: begin a = 2'b11; b = 2'b11; end
         default: ;
      endcase
      return {pcw, adr, mw, irw, rw, rs, a, b, op, il};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic run_cycle(int st, bit mr, logic [6:0] op);
      @(negedge clk);
      opcode    = op;
      mem_ready = mr;
      zero      = 1'($urandom_range(0, 1));
      #1;
      check("state", 32'(state), 32'(st));
      check("ctrl", 32'({pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                         alu_src_a, alu_src_b, alu_op, illegal}),
            32'(ctrl_exp(st, mr, zero, !is_legal(op))));
      check("retired", retired, model_ret);
   endtask

   task automatic push(int st, bit mr);
      exp_st.push_back(st);
      exp_mr.push_back(mr);
   endtask

   // One instruction: fw FETCH wait cycles, mw memory wait cycles.
   task automatic run_instr(logic [6:0] op, int fw, int mw);
      exp_st.delete();
      exp_mr.delete();
      for (int i = 0; i < fw; i++) push(0, 1'b0);
      push(0, 1'b1);
      push(1, 1'($urandom_range(0, 1)));
      case (op)
         LW: begin
            push(2, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mw; i++) push(3, 1'b0);
            push(3, 1'b1);
            push(4, 1'($urandom_range(0, 1)));
         end
         SW: begin
            push(2, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mw; i++) push(5, 1'b0);
            push(5, 1'b1);
         end
         RT: begin push(6, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
         IT: begin push(8, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
         LU: begin push(11, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
         JL: begin push(10, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
         BR: push(9, 1'($urandom_range(0, 1)));
         default: ;
      endcase
      for (int i = 0; i < exp_st.size(); i++) run_cycle(exp_st[i], exp_mr[i], op);
      if (is_legal(op)) model_ret = model_ret + 32'd1;
   endtask

   initial begin
      logic [6:0] ops [11];
      ops = '{LW, SW, RT, IT, BR, JL, LU, 7'b0000000, 7'b1111111, 7'b0010111, 7'b1100111};

      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_state", 32'(state), 32'd0);
      check("reset_retired", retired, 32'd0);

      run_instr(RT, 0, 0);
      run_instr(LW, 2, 3);
      run_instr(BR, 0, 0);
      run_instr(BR, 0, 0);
      run_instr(SW, 0, 2);
      run_instr(7'b0000000, 0, 0);
      run_instr(JL, 1, 0);
      run_instr(LU, 0, 0);

      for (int n = 0; n < 80; n++) begin
         run_instr(ops[$urandom_range(0, 10)], $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // Reset while a load is stalled in MEMRD.
      run_cycle(0, 1'b1, LW);
      run_cycle(1, 1'b1, LW);
      run_cycle(2, 1'b1, LW);
      run_cycle(3, 1'b0, LW);
      @(negedge clk);
      reset     = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      reset     = 1'b0;
      model_ret = '0;
      #1;
      check("midreset_state", 32'(state), 32'd0);
      check("midreset_retired", retired, 32'd0);
      check("midreset_ctrl", 32'({pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                                  alu_src_a, alu_src_b, alu_op, illegal}),
            32'(ctrl_exp(0, 1'b0, zero, 1'b0)));

      for (int n = 0; n < 20; n++) begin
         run_instr(ops[$urandom_range(0, 10)], $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
